// File: rtl/tpu_host_driver.sv
// Host-side job sequencer for the TPU: buffers DEPTH A/B lines, streams them to the
// accelerator, captures DEPTH result lines and drains them downstream. Optional: TPU_HOST_TIMEOUT_EN.
module tpu_host_driver #(
  parameter int IN_W   = 64,
  parameter int OUT_W  = 128,
  parameter int DEPTH  = 32,
  parameter int TO_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_a,
  input  logic [IN_W-1:0]  s_b,
  output logic             acc_in_valid,
  output logic [IN_W-1:0]  acc_a,
  output logic [IN_W-1:0]  acc_b,
  input  logic             acc_out_valid,
  input  logic [OUT_W-1:0] acc_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             err
);

  localparam int CW = 6;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  generate
    if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
      $error("tpu_host_driver: DEPTH must be within 2..64");
    end
    if (TO_CYC < 1) begin : g_bad_to_cyc
      $error("tpu_host_driver: TO_CYC must be at least 1");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
  // the accelerator side has no ready, every acc_out_valid beat in WAIT/CAPT is taken.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    CAPT  = 3'd4,
    DRAIN = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc_in_valid_q, acc_in_valid_d;
  logic [IN_W-1:0]   acc_a_q, acc_a_d;
  logic [IN_W-1:0]   acc_b_q, acc_b_d;

  logic [IN_W-1:0]   a_mem [DEPTH];
  logic [IN_W-1:0]   b_mem [DEPTH];
  logic [OUT_W-1:0]  r_mem [DEPTH];

  logic              in_we;
  logic              res_we;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     idx_nxt;
  logic              cap_beat;
  logic              cap_done;
  logic              to_fire;

  assign idx      = cnt_q[AW-1:0];
  assign idx_nxt  = idx + AW'(1);
  assign cap_beat = ((state_q == WAIT) || (state_q == CAPT)) && acc_out_valid;
  assign cap_done = cap_beat && (cnt_q == LAST);

`ifdef TPU_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;

  always_comb begin
    to_cnt_d = '0;
    to_fire  = 1'b0;
    err_d    = err_q;
    if ((state_q == WAIT) || (state_q == CAPT)) begin
      to_cnt_d = to_cnt_q + TW'(1);
      // The TO_CYC-th waiting cycle aborts unless it also delivers the final beat.
      if ((to_cnt_q == TW'(TO_CYC - 1)) && !cap_done) begin
        to_fire  = 1'b1;
        err_d    = 1'b1;
        to_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign to_fire = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_in_valid_d = 1'b0;
    acc_a_d        = '0;
    acc_b_d        = '0;
    in_we          = 1'b0;
    res_we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (s_valid) begin
          in_we = 1'b1;
          if (cnt_q == LAST) begin
            // Line 0 goes out on the edge that accepts the last line, so the burst
            // starts the very next cycle.
            state_d        = SEND;
            cnt_d          = '0;
            acc_in_valid_d = 1'b1;
            acc_a_d        = a_mem[AW'(0)];
            acc_b_d        = b_mem[AW'(0)];
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      SEND: begin
        // cnt is the line currently presented; preload the following one.
        if (cnt_q == LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d          = cnt_q + CW'(1);
          acc_in_valid_d = 1'b1;
          acc_a_d        = a_mem[idx_nxt];
          acc_b_d        = b_mem[idx_nxt];
        end
      end
      WAIT, CAPT: begin
        if (cap_beat) begin
          res_we = 1'b1;
          if (cap_done) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            state_d = CAPT;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (to_fire) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      acc_in_valid_q <= 1'b0;
      acc_a_q        <= '0;
      acc_b_q        <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_in_valid_q <= acc_in_valid_d;
      acc_a_q        <= acc_a_d;
      acc_b_q        <= acc_b_d;
    end
  end

  // Line storage carries no reset; every read is gated by the FSM state.
  always_ff @(posedge clk) begin
    if (in_we) begin
      a_mem[idx] <= s_a;
      b_mem[idx] <= s_b;
    end
    if (res_we) begin
      r_mem[idx] <= acc_out;
    end
  end

  assign s_ready      = (state_q == FILL);
  assign busy         = (state_q != IDLE);
  assign acc_in_valid = acc_in_valid_q;
  assign acc_a        = acc_a_q;
  assign acc_b        = acc_b_q;
  assign m_valid      = (state_q == DRAIN);
  assign m_data       = m_valid ? r_mem[idx] : '0;
  assign m_last       = m_valid && (cnt_q == LAST);

endmodule

// File: tb/tb_tpu_host_driver.sv
// Bench for tpu_host_driver: job-level reference model with per-cycle output compare,
// directed scenarios with literal expectations and randomized jobs.
module tb_tpu_host_driver;

  localparam int IN_W   = 64;
  localparam int OUT_W  = 128;
  localparam int DEPTH  = 32;
  localparam int TO_CYC = 1024;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [IN_W-1:0]  s_a = '0;
  logic [IN_W-1:0]  s_b = '0;
  logic             acc_in_valid;
  logic [IN_W-1:0]  acc_a;
  logic [IN_W-1:0]  acc_b;
  logic             acc_out_valid = 1'b0;
  logic [OUT_W-1:0] acc_out = '0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic             busy;
  logic             err;

  always #5 clk = ~clk;

  tpu_host_driver #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH),
    .TO_CYC(TO_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_a          (s_a),
    .s_b          (s_b),
    .acc_in_valid (acc_in_valid),
    .acc_a        (acc_a),
    .acc_b        (acc_b),
    .acc_out_valid(acc_out_valid),
    .acc_out      (acc_out),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .err          (err)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (job level) ----------------
  logic [IN_W-1:0]  up_a  [DEPTH];
  logic [IN_W-1:0]  up_b  [DEPTH];
  logic [OUT_W-1:0] res_m [DEPTH];
  int n_up = 0, n_sent = 0, n_cap = 0, n_drn = 0;
  bit exp_busy = 1'b0;
  bit exp_err = 1'b0;
`ifdef TPU_HOST_TIMEOUT_EN
  int wcyc = 0;
`endif

  // observation logs, only appended here and only read by the main flow
  logic [IN_W-1:0]  obs_a[$];
  logic [IN_W-1:0]  obs_b[$];
  logic [OUT_W-1:0] obs_m[$];
  logic [OUT_W-1:0] obs_mv[$];
  int last_cnt = 0;
  logic [OUT_W-1:0] last_data = '0;

  bit e_srdy, e_acc, e_mv, cap_phase, job_start, cap_fin;

  task automatic job_clear();
    n_up = 0; n_sent = 0; n_cap = 0; n_drn = 0; exp_busy = 1'b0;
`ifdef TPU_HOST_TIMEOUT_EN
    wcyc = 0;
`endif
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      job_clear();
      exp_err = 1'b0;
    end else begin
      e_srdy = exp_busy && (n_up < DEPTH);
      e_acc  = (n_up == DEPTH) && (n_sent < DEPTH);
      e_mv   = (n_cap == DEPTH) && (n_drn < DEPTH);

      chk("s_ready", s_ready, e_srdy);
      chk("busy", busy, exp_busy);
      chk("err", err, exp_err);
      chk("acc_in_valid", acc_in_valid, e_acc);
      chk("acc_a", acc_a, e_acc ? up_a[n_sent] : '0);
      chk("acc_b", acc_b, e_acc ? up_b[n_sent] : '0);
      chk("m_valid", m_valid, e_mv);
      chk("m_data", m_data, e_mv ? res_m[n_drn] : '0);
      chk("m_last", m_last, e_mv && (n_drn == DEPTH - 1));

      if (acc_in_valid) begin
        obs_a.push_back(acc_a);
        obs_b.push_back(acc_b);
      end
      if (m_valid) begin
        obs_mv.push_back(m_data);
        if (m_ready) obs_m.push_back(m_data);
      end
      if (m_last) begin
        last_cnt++;
        last_data = m_data;
      end

      job_start = !exp_busy && s_valid;
      cap_phase = (n_sent == DEPTH) && (n_cap < DEPTH);
      if (s_valid && e_srdy) begin
        up_a[n_up] = s_a;
        up_b[n_up] = s_b;
        n_up++;
      end
      if (e_acc) n_sent++;
      if (cap_phase) begin
        cap_fin = acc_out_valid && (n_cap == DEPTH - 1);
        if (acc_out_valid) begin
          res_m[n_cap] = acc_out;
          n_cap++;
        end
`ifdef TPU_HOST_TIMEOUT_EN
        if (!cap_fin) begin
          wcyc++;
          if (wcyc == TO_CYC) begin
            exp_err = 1'b1;
            job_clear();
          end
        end
`endif
      end
      if (e_mv && m_ready) begin
        n_drn++;
        if (n_drn == DEPTH) job_clear();
      end
      if (job_start) exp_busy = 1'b1;
    end
  end

  // ---------------- downstream ready driver ----------------
  int mr_mode = 0;
  int stall_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    case (mr_mode)
      1: begin
        if (m_valid && (n_drn == 10) && (stall_cnt < 5)) begin
          m_ready = 1'b0;
          stall_cnt++;
        end else begin
          m_ready = 1'b1;
        end
      end
      2: m_ready = ($urandom_range(0, 2) != 0);
      default: begin
        m_ready = 1'b1;
        stall_cnt = 0;
      end
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic push_line(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    int budget;
    budget = 0;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    @(negedge clk);
    while (!s_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!s_ready) chk("upstream_accept_timeout", s_ready, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one idle cycle between lines, 2: random data and gaps
  task automatic push_job(input int mode, input int base);
    logic [IN_W-1:0] a, b;
    int gap;
    @(posedge clk);
    #1;
    for (int k = 0; k < DEPTH; k++) begin
      if (mode == 2) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        gap = $urandom_range(0, 2);
      end else begin
        a = IN_W'(base + k);
        b = IN_W'(base + k + 100);
        gap = (mode == 1) ? 1 : 0;
      end
      push_line(a, b);
      if (k != DEPTH - 1) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_send_done();
    int budget;
    budget = 0;
    @(negedge clk);
    while (acc_in_valid && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("send_done_timeout", acc_in_valid, 1'b0);
  endtask

  // mode 0: contiguous beats with value k*3, 1: random values and gaps
  task automatic drive_acc(input int nbeats, input int mode);
    @(posedge clk);
    #1;
    for (int k = 0; k < nbeats; k++) begin
      acc_out_valid = 1'b1;
      acc_out = (mode == 1) ? {$urandom, $urandom, $urandom, $urandom} : OUT_W'(k * 3);
      @(posedge clk);
      #1;
      acc_out_valid = 1'b0;
      if (mode == 1) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    acc_out = '0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    @(negedge clk);
    while (busy && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    chk("job_done_timeout", busy, 1'b0);
  endtask

  // ---------------- main flow ----------------
  int ba, bm, bmv, lc, n30, b6;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_acc_in_valid", acc_in_valid, 1'b0);
    chk("rst_acc_a", acc_a, '0);
    chk("rst_acc_b", acc_b, '0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // back-to-back fill, contiguous results k*3
    ba = obs_a.size(); bm = obs_m.size(); lc = last_cnt;
    push_job(0, 0);
    wait_send_done();
    drive_acc(DEPTH, 0);
    wait_idle();
    chk("t1_burst_len", obs_a.size() - ba, 32);
    chk("t1_acc_a_first", obs_a[ba], 0);
    chk("t1_acc_a_last", obs_a[ba + 31], 31);
    chk("t1_acc_b_first", obs_b[ba], 100);
    chk("t1_acc_b_last", obs_b[ba + 31], 131);
    chk("t1_m_count", obs_m.size() - bm, 32);
    chk("t1_m_first", obs_m[bm], 0);
    chk("t1_m_second", obs_m[bm + 1], 3);
    chk("t1_m_last_line", obs_m[bm + 31], 93);
    chk("t1_m_last_count", last_cnt - lc, 1);
    chk("t1_m_last_data", last_data, 93);

    // upstream toggling every other cycle
    ba = obs_a.size();
    push_job(1, 200);
    wait_send_done();
    drive_acc(DEPTH, 0);
    wait_idle();
    chk("t2_burst_len", obs_a.size() - ba, 32);
    chk("t2_acc_a_line5", obs_a[ba + 5], 205);
    chk("t2_acc_b_last", obs_b[ba + 31], 331);

    // downstream stall of 5 cycles at line 10
    bm = obs_m.size(); bmv = obs_mv.size();
    mr_mode = 1;
    push_job(0, 0);
    wait_send_done();
    drive_acc(DEPTH, 0);
    wait_idle();
    mr_mode = 0;
    n30 = 0;
    for (int i = bmv; i < obs_mv.size(); i++) if (obs_mv[i] == 30) n30++;
    chk("t3_hold_cycles", n30, 6);
    chk("t3_valid_cycles", obs_mv.size() - bmv, 37);
    chk("t3_m_count", obs_m.size() - bm, 32);
    chk("t3_m_line10", obs_m[bm + 10], 30);
    chk("t3_m_line11", obs_m[bm + 11], 33);
    chk("t3_m_line31", obs_m[bm + 31], 93);

    // 34 beats: extra two are ignored
    bm = obs_m.size(); lc = last_cnt;
    push_job(0, 0);
    wait_send_done();
    drive_acc(DEPTH + 2, 0);
    wait_idle();
    chk("t4_m_count", obs_m.size() - bm, 32);
    chk("t4_m_line31", obs_m[bm + 31], 93);
    chk("t4_m_last_count", last_cnt - lc, 1);

    // randomized jobs
    for (int j = 0; j < 4; j++) begin
      mr_mode = 2;
      push_job(2, 0);
      wait_send_done();
      drive_acc(DEPTH + $urandom_range(0, 2), 1);
      wait_idle();
      mr_mode = 0;
    end

    // reset while line 15 is being sent
    push_job(0, 0);
    b6 = 0;
    do begin
      @(posedge clk);
      #1;
      b6++;
    end while (!(acc_in_valid && acc_a == 15) && b6 < 80);
    chk("t6_reached_line15", acc_a, 15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_acc_in_valid", acc_in_valid, 1'b0);
    chk("t6_acc_a", acc_a, '0);
    chk("t6_acc_b", acc_b, '0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_m_valid", m_valid, 1'b0);
    chk("t6_s_ready", s_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bm = obs_m.size();
    drive_acc(DEPTH, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("t6_no_results_after_abort", obs_m.size() - bm, 0);
    push_job(2, 0);
    wait_send_done();
    drive_acc(DEPTH, 1);
    wait_idle();

`ifdef TPU_HOST_TIMEOUT_EN
    // accelerator never answers
    push_job(0, 0);
    wait_send_done();
    b6 = 0;
    while (!err && b6 < TO_CYC + 50) begin
      @(negedge clk);
      b6++;
    end
    chk("t8_err_set", err, 1'b1);
    chk("t8_busy_clear", busy, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tpu_host_driver.md
TPU_HOST_DRIVER -- requirements
Module: tpu_host_driver

Interface
REQ-001 Parameters SHALL be: IN_W, 64, width of one A/B buffer line; OUT_W, 128, width of one result line; DEPTH, 32, lines per job; TO_CYC, 1024, timeout limit (used only with TPU_HOST_TIMEOUT_EN).
REQ-002 The clock SHALL be clk; the reset SHALL be rst_n, asynchronous, active-low.
REQ-003 Ports SHALL be, as name direction width meaning:
 clk  in  1  clock
 rst_n  in  1  async active-low reset
 s_valid  in  1  upstream A/B line valid
 s_ready  out  1  driver accepts upstream line
 s_a  in  IN_W  upstream A line
 s_b  in  IN_W  upstream B line
 acc_in_valid  out  1  in_valid to accelerator
 acc_a  out  IN_W  gbuff_a to accelerator
 acc_b  out  IN_W  gbuff_b to accelerator
 acc_out_valid  in  1  out_valid from accelerator
 acc_out  in  OUT_W  gbuff_out from accelerator
 m_valid  out  1  result line valid downstream
 m_ready  in  1  downstream accepts result line
 m_data  out  OUT_W  result line
 m_last  out  1  marks line DEPTH-1 of job
 busy  out  1  job in progress (state != IDLE)
 err  out  1  sticky timeout flag (0 without TPU_HOST_TIMEOUT_EN)

Function
REQ-004 The FSM SHALL have states IDLE, FILL, SEND, WAIT, CAPT, DRAIN; a 6-bit line counter cnt SHALL index both buffers.
REQ-005 IDLE -> FILL on s_valid=1; cnt=0.
REQ-006 In FILL, s_ready=1; each cycle with s_valid&s_ready SHALL write {s_a,s_b} to input buffer[cnt] and increment cnt; upstream gaps SHALL be tolerated; after line DEPTH-1 is accepted -> SEND, cnt=0.
REQ-007 In SEND, acc_in_valid SHALL be 1 for exactly DEPTH consecutive cycles, presenting buffer[0..DEPTH-1] registered on acc_a/acc_b in order, no gaps; then -> WAIT.
REQ-008 Outside SEND, acc_in_valid=0 and acc_a=acc_b=0.
REQ-009 WAIT -> CAPT on first acc_out_valid=1; that beat SHALL be stored as result line 0.
REQ-010 In CAPT, every cycle acc_out_valid=1 SHALL store acc_out to result buffer[cnt] and increment cnt; acc_out_valid beats after DEPTH lines SHALL be ignored; -> DRAIN once DEPTH lines are stored.
REQ-011 No backpressure SHALL exist toward the accelerator; capture SHALL never drop a beat within the first DEPTH.
REQ-012 In DRAIN, m_valid=1 and m_data=result buffer[cnt]; cnt SHALL advance only on m_valid&m_ready; m_data SHALL be held stable while m_ready=0; m_last=1 with line DEPTH-1; after that handshake -> IDLE.
REQ-013 s_ready SHALL be 0 in every state except FILL; m_valid SHALL be 0 except in DRAIN.
REQ-014 Output latency SHALL be: first acc_in_valid one cycle after the last FILL handshake; first m_valid one cycle after the DEPTH-th captured beat.

Reset
REQ-015 On rst_n=0, the FSM SHALL go to IDLE, cnt=0, and s_ready, acc_in_valid, acc_a, acc_b, m_valid, m_data, m_last, busy, err SHALL be 0; buffer contents are not reset.
REQ-016 Reset mid-job SHALL abort it; no partial results SHALL be emitted afterwards.

Configuration
REQ-017 With TPU_HOST_TIMEOUT_EN defined, a counter SHALL run in WAIT and CAPT; reaching TO_CYC cycles without completing capture SHALL set err=1 (sticky until reset) and force IDLE.
REQ-018 Without TPU_HOST_TIMEOUT_EN, no counter SHALL exist, err SHALL be tied 0, and WAIT SHALL wait indefinitely.

Verification
REQ-019 32 back-to-back upstream lines A=k, B=k+100 -> acc_in_valid high 32 consecutive cycles, acc_a=0..31, acc_b=100..131.
REQ-020 Upstream s_valid toggling every other cycle -> SEND still contiguous 32 cycles, data order intact.
REQ-021 acc_out_valid 32 beats acc_out=k*3, m_ready=1 -> m_data=0,3..93 on 32 cycles, m_last only with 93.
REQ-022 m_ready low 5 cycles at line 10 -> m_data=30 held, no loss, then 33..93.
REQ-023 acc_out_valid 34 beats -> only first 32 captured, beats 33-34 ignored.
REQ-024 rst_n low during SEND line 15 -> all outputs 0 next cycle, busy=0; with TPU_HOST_TIMEOUT_EN, TO_CYC=1024 and no acc_out_valid -> err=1 after 1024 cycles, FSM IDLE.
